layer_compositor: RTL and testbench

- Per-pixel layer resolver sitting directly upstream of the palette stage, and also consuming its output.
- Accepts one pixel's stack of per-layer 5-bit colour indices and selects the top-most opaque layer. Layer 0 is highest priority; colour index 0 is transparent.
- Drives the palette pipeline read address and captures the returned RGB888. When no layer is opaque, substitutes a programmable background colour.
- Emits a valid/ready RGB stream toward the HDMI output path.

---
 rtl/compositor_pkg.sv | 20 ++
 rtl/layer_priority_enc.sv | 35 +++
 rtl/layer_compositor.sv | 118 +++++++++++
 tb/tb_layer_compositor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - shared constants and stage record for the layer compositor
// Purpose: widths, the transparent index value and the S1 pipeline record.
// Ports: none (package).
package compositor_pkg;

   localparam int IDX_W   = 5;
   localparam int LAYER_W = 5;
   localparam int RGB_W   = 24;

   localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

   typedef struct packed {
      logic               found;
      logic [LAYER_W-1:0] layer;
      logic [IDX_W-1:0]   color;
      logic               sof;
      logic               eol;
   } s1_rec_t;

endpackage

// File: rtl/layer_priority_enc.sv
// rtl/layer_priority_enc.sv - combinational top-most opaque layer selector
// Purpose: finds the lowest-numbered enabled layer whose colour index is not transparent.
// Ports:
//   indices  in   NUM_LAYERS*IDX_W  per-layer colour indices, layer L at [IDX_W*L +: IDX_W]
//   layer_en in   NUM_LAYERS        per-layer enable
//   found    out  1                 some layer is opaque
//   layer    out  LAYER_W           winning layer, 0 when none
//   color    out  IDX_W             winning colour index, 0 when none
module layer_priority_enc #(
   parameter int NUM_LAYERS = 32
) (
   input  logic [NUM_LAYERS*compositor_pkg::IDX_W-1:0] indices,
   input  logic [NUM_LAYERS-1:0]                       layer_en,
   output logic                                        found,
   output logic [compositor_pkg::LAYER_W-1:0]          layer,
   output logic [compositor_pkg::IDX_W-1:0]            color
);
   import compositor_pkg::*;

   // Scan from the bottom layer upward so the lowest opaque layer overwrites
   // any higher-numbered candidate and ends up as the winner.
   always_comb begin
      found = 1'b0;
      layer = '0;
      color = '0;
      for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
         if (layer_en[l] && (indices[l*IDX_W +: IDX_W] != TRANSPARENT_IDX)) begin
            found = 1'b1;
            layer = LAYER_W'(l);
            color = indices[l*IDX_W +: IDX_W];
         end
      end
   end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - per-pixel layer resolver feeding the palette and the HDMI stream
// Purpose: resolves the top-most opaque layer, reads its colour from the palette,
//          substitutes the background colour when nothing is opaque.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          input pixel handshake
//   in_indices, in_layer_en    per-layer colour indices and enables
//   in_sof, in_eol             frame/line markers, passed through
//   pipeLayer, pipeColor       registered palette read address
//   pipeReadData, pixelFound   palette response (same cycle)
//   bg_we, bg_color            background colour write
//   out_valid/out_ready        output pixel handshake
//   out_rgb, out_layer, out_opaque, out_sof, out_eol  resolved pixel
module layer_compositor #(
   parameter int NUM_LAYERS = 32,
   parameter int IDX_W      = compositor_pkg::IDX_W,
   parameter int RGB_W      = compositor_pkg::RGB_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [NUM_LAYERS*IDX_W-1:0]         in_indices,
   input  logic [NUM_LAYERS-1:0]               in_layer_en,
   input  logic                                in_sof,
   input  logic                                in_eol,
   output logic [compositor_pkg::LAYER_W-1:0]  pipeLayer,
   output logic [IDX_W-1:0]                    pipeColor,
   input  logic [RGB_W-1:0]                    pipeReadData,
   input  logic                                pixelFound,
   input  logic                                bg_we,
   input  logic [RGB_W-1:0]                    bg_color,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [RGB_W-1:0]                    out_rgb,
   output logic [compositor_pkg::LAYER_W-1:0]  out_layer,
   output logic                                out_opaque,
   output logic                                out_sof,
   output logic                                out_eol
);
   import compositor_pkg::*;

   logic               enc_found;
   logic [LAYER_W-1:0] enc_layer;
   logic [IDX_W-1:0]   enc_color;

   s1_rec_t          s1;
   logic             s1_valid;
   logic             stall;
   logic             s1_adv;
   logic             accept;
   logic [RGB_W-1:0] bg_reg;

   layer_priority_enc #(
      .NUM_LAYERS(NUM_LAYERS)
   ) u_enc (
      .indices  (in_indices),
      .layer_en (in_layer_en),
      .found    (enc_found),
      .layer    (enc_layer),
      .color    (enc_color)
   );

   assign stall    = out_valid && !out_ready;
   assign s1_adv   = s1_valid && !stall;
   assign in_ready = !rst && (!s1_valid || !stall);
   assign accept   = in_valid && in_ready;

   // The palette address is the S1 register itself, so it stays put while S1 is held.
   assign pipeLayer = s1.layer;
   assign pipeColor = s1.color;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= '0;
         s1_valid   <= 1'b0;
         out_valid  <= 1'b0;
         out_rgb    <= '0;
         out_layer  <= '0;
         out_opaque <= 1'b0;
         out_sof    <= 1'b0;
         out_eol    <= 1'b0;
         bg_reg     <= '0;
      end else begin
         if (bg_we) begin
            bg_reg <= bg_color;
         end

         if (accept) begin
            s1.found <= enc_found;
            s1.layer <= enc_layer;
            s1.color <= enc_color;
            s1.sof   <= in_sof;
            s1.eol   <= in_eol;
            s1_valid <= 1'b1;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         // bg_reg here is the pre-edge value, so a same-edge bg_we affects later pixels only.
         if (s1_adv) begin
            out_valid  <= 1'b1;
            out_rgb    <= s1.found ? pipeReadData : bg_reg;
            out_layer  <= s1.layer;
            out_opaque <= s1.found;
            out_sof    <= s1.sof;
            out_eol    <= s1.eol;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

   palette_flag_consistent: assert property (
      @(posedge clk) disable iff (rst) s1_valid |-> (pixelFound == (pipeColor != TRANSPARENT_IDX))
   );

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - self-checking bench for layer_compositor
module tb_layer_compositor;

   localparam int NL = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [NL*5-1:0] in_indices;
   logic [NL-1:0]  in_layer_en;
   logic           in_sof, in_eol;
   logic [4:0]     pipeLayer, pipeColor;
   logic [23:0]    pipeReadData;
   logic           pixelFound;
   logic           bg_we;
   logic [23:0]    bg_color;
   logic           out_valid, out_ready;
   logic [23:0]    out_rgb;
   logic [4:0]     out_layer;
   logic           out_opaque, out_sof, out_eol;

   int total = 0;
   int bad   = 0;

   layer_compositor #(.NUM_LAYERS(NL), .IDX_W(5), .RGB_W(24)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_indices(in_indices), .in_layer_en(in_layer_en),
      .in_sof(in_sof), .in_eol(in_eol),
      .pipeLayer(pipeLayer), .pipeColor(pipeColor),
      .pipeReadData(pipeReadData), .pixelFound(pixelFound),
      .bg_we(bg_we), .bg_color(bg_color),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rgb(out_rgb), .out_layer(out_layer), .out_opaque(out_opaque),
      .out_sof(out_sof), .out_eol(out_eol)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pal(input logic [4:0] l, input logic [4:0] c);
      if (l == 5'd3 && c == 5'd7) return 24'h112233;
      if (l == 5'd9 && c == 5'd2) return 24'hA0B0C0;
      return {l, 3'b011, c, 3'b100, l ^ {c[2:0], c[4:3]}, 3'b001};
   endfunction

   assign pipeReadData = pal(pipeLayer, pipeColor);
   assign pixelFound   = (pipeColor != 5'd0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        found;
      logic [4:0]  layer;
      logic [23:0] rgb;
      logic        sof;
      logic        eol;
      logic        seen;
      logic [23:0] bg;
   } exp_t;

   exp_t        q[$];
   logic [23:0] bg_now  = '0;
   logic [23:0] bg_last = '0;

   function automatic exp_t model(input logic [NL*5-1:0] idx, input logic [NL-1:0] en,
                                  input logic s, input logic e);
      exp_t r;
      r     = '0;
      r.sof = s;
      r.eol = e;
      for (int l = 0; l < NL; l++) begin
         if (en[l] && idx[l*5 +: 5] != 5'd0) begin
            r.found = 1'b1;
            r.layer = 5'(l);
            r.rgb   = pal(5'(l), idx[l*5 +: 5]);
            break;
         end
      end
      return r;
   endfunction

   // Reference model: queue of accepted pixels; the head is whatever the output must show.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         bg_now  = '0;
         bg_last = '0;
      end else begin
         chk("in_ready", 32'(in_ready), 32'(!(q.size() >= 2 && out_valid && !out_ready)));
         if (out_valid) begin
            chk("pixel_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               if (!q[0].seen) begin
                  q[0].seen = 1'b1;
                  q[0].bg   = bg_last;
               end
               chk("out_rgb",    32'(out_rgb),    32'(q[0].found ? q[0].rgb : q[0].bg));
               chk("out_layer",  32'(out_layer),  32'(q[0].layer));
               chk("out_opaque", 32'(out_opaque), 32'(q[0].found));
               chk("out_sof",    32'(out_sof),    32'(q[0].sof));
               chk("out_eol",    32'(out_eol),    32'(q[0].eol));
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_indices, in_layer_en, in_sof, in_eol));
         bg_last = bg_now;
         if (bg_we) bg_now = bg_color;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [NL*5-1:0] idx, input logic [NL-1:0] en,
                      input logic s, input logic e);
      in_valid    = 1'b1;
      in_indices  = idx;
      in_layer_en = en;
      in_sof      = s;
      in_eol      = e;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NL*5-1:0] v;
      logic [NL-1:0]   en;
      int              guard;

      rst = 1'b1; in_valid = 1'b0; in_indices = '0; in_layer_en = '0;
      in_sof = 1'b0; in_eol = 1'b0; bg_we = 1'b0; bg_color = '0; out_ready = 1'b1;
      repeat (3) step();
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_out_rgb",    32'(out_rgb),    32'd0);
      chk("rst_out_layer",  32'(out_layer),  32'd0);
      chk("rst_out_opaque", 32'(out_opaque), 32'd0);
      chk("rst_out_sof",    32'(out_sof),    32'd0);
      chk("rst_out_eol",    32'(out_eol),    32'd0);
      chk("rst_pipeLayer",  32'(pipeLayer),  32'd0);
      chk("rst_pipeColor",  32'(pipeColor),  32'd0);
      chk("rst_in_ready",   32'(in_ready),   32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Layer 3 idx 7 beats layer 9 idx 2
      v = '0; v[3*5 +: 5] = 5'd7; v[9*5 +: 5] = 5'd2;
      put(v, '1, 1'b0, 1'b0); step(); idle();
      chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
      chk("t1_pipeLayer",     32'(pipeLayer), 32'd3);
      chk("t1_pipeColor",     32'(pipeColor), 32'd7);
      step();
      chk("t1_valid",  32'(out_valid),  32'd1);
      chk("t1_rgb",    32'(out_rgb),    32'h112233);
      chk("t1_layer",  32'(out_layer),  32'd3);
      chk("t1_opaque", 32'(out_opaque), 32'd1);
      step();
      chk("t1_one_beat", 32'(out_valid), 32'd0);

      // Layer 3 disabled: layer 9 wins
      en = '1; en[3] = 1'b0;
      put(v, en, 1'b0, 1'b0); step(); idle(); step();
      chk("t2_layer", 32'(out_layer),  32'd9);
      chk("t2_rgb",   32'(out_rgb),    32'hA0B0C0);
      step();

      // Background substitution
      bg_we = 1'b1; bg_color = 24'h00FF00; step(); bg_we = 1'b0;
      put('0, '1, 1'b0, 1'b0); step(); idle(); step();
      chk("bg_valid",  32'(out_valid),  32'd1);
      chk("bg_rgb",    32'(out_rgb),    32'h00FF00);
      chk("bg_opaque", 32'(out_opaque), 32'd0);
      chk("bg_layer",  32'(out_layer),  32'd0);
      step();

      // Eight pixels back to back
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            v = '0; v[((k*3) % NL)*5 +: 5] = 5'(k + 1);
            put(v, '1, k == 0, k == 7);
         end else begin
            idle();
         end
         step();
         chk("b2b_valid", 32'(out_valid), 32'(k >= 1 && k <= 8));
         chk("b2b_sof",   32'(out_sof && out_valid), 32'(k == 1));
         chk("b2b_eol",   32'(out_eol && out_valid), 32'(k == 8));
      end
      step();

      // Stall with two pixels in flight, a third offered
      out_ready = 1'b0;
      v = '0; v[2*5 +: 5] = 5'd5;   put(v, '1, 1'b0, 1'b0); step();
      v = '0; v[20*5 +: 5] = 5'd11; put(v, '1, 1'b0, 1'b0); step();
      v = '0; v[31*5 +: 5] = 5'd31; put(v, '1, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_in_ready",  32'(in_ready),  32'd0);
         chk("stall_pipeLayer", 32'(pipeLayer), 32'd20);
         chk("stall_pipeColor", 32'(pipeColor), 32'd11);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_out_layer", 32'(out_layer), 32'd2);
         chk("stall_out_rgb",   32'(out_rgb),   32'(pal(5'd2, 5'd5)));
      end
      out_ready = 1'b1;
      step(); idle();
      chk("release_first", 32'(out_layer), 32'd20);
      step();
      chk("release_second", 32'(out_layer), 32'd31);
      chk("release_eol",    32'(out_eol),   32'd1);
      step();
      chk("release_empty", 32'(out_valid), 32'd0);

      // bg write on the same edge a transparent pixel enters S2
      put('0, '1, 1'b0, 1'b0); step();
      put('0, '1, 1'b0, 1'b0); bg_we = 1'b1; bg_color = 24'hC0FFEE; step();
      bg_we = 1'b0; idle();
      chk("bg_edge_old", 32'(out_rgb), 32'h00FF00);
      step();
      chk("bg_edge_new", 32'(out_rgb), 32'hC0FFEE);
      step();

      // Reset with S1 and S2 full
      out_ready = 1'b0;
      v = '0; v[4*5 +: 5] = 5'd9;  put(v, '1, 1'b0, 1'b0); step();
      v = '0; v[6*5 +: 5] = 5'd10; put(v, '1, 1'b0, 1'b0); step(); idle();
      chk("pre_rst_full", 32'(out_valid), 32'd1);
      rst = 1'b1; step(); rst = 1'b0; #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("no_stale", 32'(out_valid), 32'd0);
      end
      put('0, '1, 1'b0, 1'b0); step(); idle(); step();
      chk("bg_after_rst", 32'(out_rgb), 32'h000000);
      step();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int l = 0; l < NL; l++)
            v[l*5 +: 5] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         en = ($urandom_range(0, 3) == 0) ? '1 : NL'($urandom() | $urandom());
         in_valid    = ($urandom_range(0, 3) != 0);
         in_indices  = v;
         in_layer_en = en;
         in_sof      = 1'($urandom_range(0, 1));
         in_eol      = 1'($urandom_range(0, 1));
         out_ready   = ($urandom_range(0, 9) < 7);
         bg_we       = ($urandom_range(0, 29) == 0);
         bg_color    = 24'($urandom());
         step();
      end

      idle(); bg_we = 1'b0; out_ready = 1'b1;
      guard = 0;
      while (q.size() != 0 && guard < 20) begin
         step();
         guard++;
      end
      step();
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
